// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch path.
package mips_pkg;

  typedef enum logic [2:0] {
    BOOT,
    REQ,
    WAIT,
    HOLD,
    HALT
  } fetch_state_e;

  typedef logic [1:0] fault_code_t;

  localparam fault_code_t FAULT_NONE     = 2'b00;
  localparam fault_code_t FAULT_MISALIGN = 2'b01;
  localparam fault_code_t FAULT_TIMEOUT  = 2'b10;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory req/ack handshake between the fetch unit (master) and imem (slave).
interface pc_fetch_unit_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/pc_fetch_unit_pc_register.sv
// Program-counter storage: WIDTH-bit register with async reset to RESET_PC and load enable.
module pc_register #(
  parameter int unsigned           WIDTH    = 32,
  parameter logic [WIDTH-1:0]      RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (en_i) begin
      pc_q <= d_i;
    end
  end

  assign q_o = pc_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC owner and instruction-fetch sequencer: req/ack to imem, holds the fetched
// instruction until commit, counts retirements and latches the first fetch fault.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned      TIMEOUT  = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     pc_next,
  input  logic                 commit,
  input  logic                 stall,
  pc_fetch_unit_if.master      imem,
  output logic [WIDTH-1:0]     instr,
  output logic                 instr_valid,
  output logic [WIDTH-1:0]     pc,
  output logic [WIDTH-1:0]     pc_plus4,
  output logic [31:0]          retired_cnt,
  output logic                 fault,
  output logic [1:0]           fault_code
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  fetch_state_e     state_q;
  logic [7:0]       wait_cnt_q;
  logic [WIDTH-1:0] instr_q;
  logic             valid_q;
  logic [31:0]      retired_q;
  logic             fault_q;
  fault_code_t      fault_code_q;

  logic             misaligned;
  logic             pc_load;

  assign misaligned = |pc_next[1:0];
  assign pc_load    = (state_q == HOLD) && commit && !misaligned;

  pc_register #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .en_i (pc_load),
    .d_i  (pc_next),
    .q_o  (pc)
  );

  assign pc_plus4       = pc + WIDTH'(PC_STEP);
  assign imem.imem_addr = pc;
  // Request is qualified by the live stall so the REQ cycle itself carries the pulse.
  assign imem.imem_req  = (state_q == REQ) && !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BOOT;
      wait_cnt_q   <= '0;
      instr_q      <= '0;
      valid_q      <= 1'b0;
      retired_q    <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= FAULT_NONE;
    end else begin
      case (state_q)
        BOOT: state_q <= REQ;
        REQ: begin
          wait_cnt_q <= '0;
          if (!stall) state_q <= WAIT;
        end
        WAIT: begin
          if (imem.imem_ack) begin
            instr_q <= imem.imem_rdata;
            valid_q <= 1'b1;
            state_q <= HOLD;
          end else if (wait_cnt_q + 8'd1 == TIMEOUT_CNT) begin
            fault_q      <= 1'b1;
            fault_code_q <= FAULT_TIMEOUT;
            state_q      <= HALT;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        HOLD: begin
          if (commit) begin
            valid_q <= 1'b0;
            if (misaligned) begin
              fault_q      <= 1'b1;
              fault_code_q <= FAULT_MISALIGN;
              state_q      <= HALT;
            end else begin
              retired_q <= retired_q + 32'd1;
              state_q   <= REQ;
            end
          end
        end
        HALT:    valid_q <= 1'b0;
        default: state_q <= HALT;
      endcase
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign retired_cnt = retired_q;
  assign fault       = fault_q;
  assign fault_code  = fault_code_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: main instance at RESET_PC=0, second at 0xBFC0_0000.
module tb_pc_fetch_unit;
  import mips_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] pc_next;
  logic        commit, stall;
  logic [31:0] instr, pc, pc_plus4, retired_cnt;
  logic        instr_valid, fault;
  logic [1:0]  fault_code;

  logic [31:0] pc_next2;
  logic        commit2, stall2;
  logic [31:0] instr2, pc2, pc_plus4_2, retired_cnt2;
  logic        instr_valid2, fault2;
  logic [1:0]  fault_code2;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  pc_fetch_unit_if #(.WIDTH(32)) imem_if ();
  pc_fetch_unit_if #(.WIDTH(32)) imem_if2 ();

  pc_fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000), .TIMEOUT(15)) u_dut (
    .clk(clk), .rst(rst), .pc_next(pc_next), .commit(commit), .stall(stall),
    .imem(imem_if.master), .instr(instr), .instr_valid(instr_valid), .pc(pc),
    .pc_plus4(pc_plus4), .retired_cnt(retired_cnt), .fault(fault), .fault_code(fault_code)
  );

  pc_fetch_unit #(.WIDTH(32), .RESET_PC(32'hBFC0_0000), .TIMEOUT(15)) u_dut2 (
    .clk(clk), .rst(rst), .pc_next(pc_next2), .commit(commit2), .stall(stall2),
    .imem(imem_if2.master), .instr(instr2), .instr_valid(instr_valid2), .pc(pc2),
    .pc_plus4(pc_plus4_2), .retired_cnt(retired_cnt2), .fault(fault2), .fault_code(fault_code2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From a REQ cycle: advance to WAIT, ack with w, land in HOLD.
  task automatic fetch(input logic [31:0] w);
    tick();
    imem_if.imem_ack   = 1'b1;
    imem_if.imem_rdata = w;
    tick();
    imem_if.imem_ack   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; commit = 1'b0; pc_next = '0;
    imem_if.imem_ack = 1'b0; imem_if.imem_rdata = '0;
    pc_next2 = '0; commit2 = 1'b0; stall2 = 1'b0;
    imem_if2.imem_ack = 1'b0; imem_if2.imem_rdata = '0;
    tick(); tick();
    n_checks++; if (pc !== 32'h0) $display("FAIL reset_pc got %h exp %h", pc, 32'h0); else n_pass++;
    n_checks++; if (instr !== 32'h0) $display("FAIL reset_instr got %h exp %h", instr, 32'h0); else n_pass++;
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", instr_valid); else n_pass++;
    n_checks++; if (imem_if.imem_req !== 1'b0) $display("FAIL reset_req got %b exp 0", imem_if.imem_req); else n_pass++;
    n_checks++; if (retired_cnt !== 32'h0) $display("FAIL reset_retired got %0d exp 0", retired_cnt); else n_pass++;
    n_checks++; if (fault !== 1'b0 || fault_code !== 2'b00) $display("FAIL reset_fault got %b/%b exp 0/00", fault, fault_code); else n_pass++;
    n_checks++; if (pc_plus4 !== 32'h4) $display("FAIL reset_pc_plus4 got %h exp %h", pc_plus4, 32'h4); else n_pass++;
    n_checks++; if (pc2 !== 32'hBFC0_0000) $display("FAIL reset_pc_alt got %h exp %h", pc2, 32'hBFC0_0000); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_first_fetch();
    tick();
    n_checks++; if (imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== 32'h0) $display("FAIL first_req got %b@%h exp 1@%h", imem_if.imem_req, imem_if.imem_addr, 32'h0); else n_pass++;
    n_checks++; if (imem_if2.imem_req !== 1'b1 || imem_if2.imem_addr !== 32'hBFC0_0000) $display("FAIL alt_req got %b@%h exp 1@%h", imem_if2.imem_req, imem_if2.imem_addr, 32'hBFC0_0000); else n_pass++;
    n_checks++; if (pc_plus4_2 !== 32'hBFC0_0004) $display("FAIL alt_pc_plus4 got %h exp %h", pc_plus4_2, 32'hBFC0_0004); else n_pass++;
    tick();
    n_checks++; if (imem_if.imem_req !== 1'b0) $display("FAIL wait_req got %b exp 0", imem_if.imem_req); else n_pass++;
    imem_if.imem_ack = 1'b1; imem_if.imem_rdata = 32'h2002_0005;
    tick();
    imem_if.imem_ack = 1'b0;
    n_checks++; if (instr !== 32'h2002_0005 || instr_valid !== 1'b1) $display("FAIL first_instr got %h/%b exp %h/1", instr, instr_valid, 32'h2002_0005); else n_pass++;
    commit = 1'b1; pc_next = 32'h4;
    tick();
    commit = 1'b0;
    n_checks++; if (pc !== 32'h4) $display("FAIL first_commit_pc got %h exp %h", pc, 32'h4); else n_pass++;
    n_checks++; if (retired_cnt !== 32'd1) $display("FAIL first_retired got %0d exp 1", retired_cnt); else n_pass++;
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL first_valid_clear got %b exp 0", instr_valid); else n_pass++;
    n_checks++; if (imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== 32'h4) $display("FAIL second_req got %b@%h exp 1@%h", imem_if.imem_req, imem_if.imem_addr, 32'h4); else n_pass++;
  endtask

  task automatic test_branch();
    fetch(32'h8C01_0000);
    commit = 1'b1; pc_next = 32'h0000_0040;
    tick();
    commit = 1'b0;
    n_checks++; if (imem_if.imem_addr !== 32'h40) $display("FAIL branch_addr got %h exp %h", imem_if.imem_addr, 32'h40); else n_pass++;
    n_checks++; if (pc_plus4 !== 32'h44) $display("FAIL branch_pc_plus4 got %h exp %h", pc_plus4, 32'h44); else n_pass++;
    n_checks++; if (retired_cnt !== 32'd2) $display("FAIL branch_retired got %0d exp 2", retired_cnt); else n_pass++;
  endtask

  task automatic test_stall();
    stall = 1'b1;
    #1;
    n_checks++; if (imem_if.imem_req !== 1'b0) $display("FAIL stall_req0 got %b exp 0", imem_if.imem_req); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (imem_if.imem_req !== 1'b0) $display("FAIL stall_req_%0d got %b exp 0", i, imem_if.imem_req); else n_pass++;
    end
    stall = 1'b0;
    #1;
    n_checks++; if (imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== 32'h40) $display("FAIL stall_release got %b@%h exp 1@%h", imem_if.imem_req, imem_if.imem_addr, 32'h40); else n_pass++;
    tick();
    n_checks++; if (imem_if.imem_req !== 1'b0) $display("FAIL stall_pulse_end got %b exp 0", imem_if.imem_req); else n_pass++;
    imem_if.imem_ack = 1'b1; imem_if.imem_rdata = 32'h0085_1020;
    tick();
    imem_if.imem_ack = 1'b0;
    n_checks++; if (instr !== 32'h0085_1020 || instr_valid !== 1'b1) $display("FAIL stall_instr got %h/%b exp %h/1", instr, instr_valid, 32'h0085_1020); else n_pass++;
  endtask

  task automatic test_commit_stall();
    commit = 1'b1; stall = 1'b1; pc_next = 32'h44;
    tick();
    n_checks++; if (pc !== 32'h44 || retired_cnt !== 32'd3) $display("FAIL cstall_retire got %h/%0d exp %h/3", pc, retired_cnt, 32'h44); else n_pass++;
    n_checks++; if (imem_if.imem_req !== 1'b0 || instr_valid !== 1'b0) $display("FAIL cstall_req got %b/%b exp 0/0", imem_if.imem_req, instr_valid); else n_pass++;
    pc_next = 32'h80;
    tick();
    n_checks++; if (pc !== 32'h44 || retired_cnt !== 32'd3) $display("FAIL commit_outside_hold got %h/%0d exp %h/3", pc, retired_cnt, 32'h44); else n_pass++;
    commit = 1'b0; stall = 1'b0;
    #1;
    n_checks++; if (imem_if.imem_req !== 1'b1) $display("FAIL cstall_release got %b exp 1", imem_if.imem_req); else n_pass++;
  endtask

  task automatic test_ack_outside_wait();
    fetch(32'hAAAA_0001);
    imem_if.imem_ack = 1'b1; imem_if.imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_if.imem_ack = 1'b0;
    n_checks++; if (instr !== 32'hAAAA_0001 || instr_valid !== 1'b1) $display("FAIL ack_in_hold got %h/%b exp %h/1", instr, instr_valid, 32'hAAAA_0001); else n_pass++;
  endtask

  task automatic test_wrap();
    commit = 1'b1; pc_next = 32'hFFFF_FFFC;
    tick();
    commit = 1'b0;
    n_checks++; if (pc !== 32'hFFFF_FFFC || imem_if.imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_pc got %h/%h exp %h", pc, imem_if.imem_addr, 32'hFFFF_FFFC); else n_pass++;
    n_checks++; if (pc_plus4 !== 32'h0) $display("FAIL wrap_pc_plus4 got %h exp %h", pc_plus4, 32'h0); else n_pass++;
    n_checks++; if (retired_cnt !== 32'd4) $display("FAIL wrap_retired got %0d exp 4", retired_cnt); else n_pass++;
  endtask

  task automatic test_misalign();
    fetch(32'h1111_1111);
    commit = 1'b1; pc_next = 32'h0000_0042;
    tick();
    commit = 1'b0;
    n_checks++; if (fault !== 1'b1 || fault_code !== 2'b01) $display("FAIL misalign_fault got %b/%b exp 1/01", fault, fault_code); else n_pass++;
    n_checks++; if (pc !== 32'hFFFF_FFFC) $display("FAIL misalign_pc got %h exp %h", pc, 32'hFFFF_FFFC); else n_pass++;
    n_checks++; if (retired_cnt !== 32'd4) $display("FAIL misalign_retired got %0d exp 4", retired_cnt); else n_pass++;
    n_checks++; if (instr_valid !== 1'b0 || imem_if.imem_req !== 1'b0) $display("FAIL misalign_halt got %b/%b exp 0/0", instr_valid, imem_if.imem_req); else n_pass++;
    imem_if.imem_ack = 1'b1;
    tick(); tick();
    imem_if.imem_ack = 1'b0;
    n_checks++; if (instr_valid !== 1'b0 || imem_if.imem_req !== 1'b0 || fault_code !== 2'b01) $display("FAIL halt_sticky got %b/%b/%b exp 0/0/01", instr_valid, imem_if.imem_req, fault_code); else n_pass++;
  endtask

  task automatic test_timeout();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    n_checks++; if (imem_if.imem_req !== 1'b1) $display("FAIL to_req got %b exp 1", imem_if.imem_req); else n_pass++;
    tick();
    for (int i = 0; i < 14; i++) tick();
    n_checks++; if (fault !== 1'b0) $display("FAIL to_early got %b exp 0", fault); else n_pass++;
    tick();
    n_checks++; if (fault !== 1'b1 || fault_code !== 2'b10) $display("FAIL to_fault got %b/%b exp 1/10", fault, fault_code); else n_pass++;
    n_checks++; if (fault2 !== 1'b1 || fault_code2 !== 2'b10 || pc2 !== 32'hBFC0_0000) $display("FAIL to_fault_alt got %b/%b/%h exp 1/10/%h", fault2, fault_code2, pc2, 32'hBFC0_0000); else n_pass++;
    imem_if.imem_ack = 1'b1; imem_if.imem_rdata = 32'h1234_5678;
    tick();
    imem_if.imem_ack = 1'b0;
    n_checks++; if (instr_valid !== 1'b0 || imem_if.imem_req !== 1'b0) $display("FAIL to_late_ack got %b/%b exp 0/0", instr_valid, imem_if.imem_req); else n_pass++;
  endtask

  task automatic test_reset_in_wait();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    fetch(32'h0000_0001);
    commit = 1'b1; pc_next = 32'h100;
    tick();
    commit = 1'b0;
    n_checks++; if (pc !== 32'h100) $display("FAIL rw_setup_pc got %h exp %h", pc, 32'h100); else n_pass++;
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (pc !== 32'h0 || imem_if.imem_addr !== 32'h0) $display("FAIL rw_pc got %h/%h exp 0", pc, imem_if.imem_addr); else n_pass++;
    n_checks++; if (instr !== 32'h0 || instr_valid !== 1'b0 || imem_if.imem_req !== 1'b0) $display("FAIL rw_instr got %h/%b/%b exp 0/0/0", instr, instr_valid, imem_if.imem_req); else n_pass++;
    n_checks++; if (retired_cnt !== 32'h0 || fault !== 1'b0 || fault_code !== 2'b00) $display("FAIL rw_cnt got %0d/%b/%b exp 0/0/00", retired_cnt, fault, fault_code); else n_pass++;
    imem_if.imem_ack = 1'b1; imem_if.imem_rdata = 32'hFFFF_0000;
    #2;
    rst = 1'b0;
    tick();
    n_checks++; if (instr_valid !== 1'b0 || instr !== 32'h0) $display("FAIL rw_late_ack got %h/%b exp 0/0", instr, instr_valid); else n_pass++;
    imem_if.imem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_branch();
    test_stall();
    test_commit_stall();
    test_ack_outside_wait();
    test_wrap();
    test_misalign();
    test_timeout();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
